// File: rtl/whack_input_encoder.sv
// Mole pushbutton front end: sync, debounce, edge-detect, encode one hit.
// Optional PRESS_COUNT_EN adds a saturating accepted-press counter.
module whack_input_encoder #(
  parameter int NUM_KEYS        = 5,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLD_CYCLES     = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic [NUM_KEYS-1:0] rawKeys,
  output logic [2:0]          userGameInput,
  output logic                hitPulse,
`ifdef PRESS_COUNT_EN
  output logic                multiPress,
  output logic [7:0]          pressCount
`else
  output logic                multiPress
`endif
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = (HOLD_CYCLES > 1) ?
                      $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    RELEASE_WAIT
  } state_t;

  logic [NUM_KEYS-1:0] syncMeta;
  logic [NUM_KEYS-1:0] syncKey;
  logic [NUM_KEYS-1:0] stable;
  logic [NUM_KEYS-1:0] stablePrev;
  logic [NUM_KEYS-1:0] press;
  logic [CW-1:0]       debCnt [NUM_KEYS];

  state_t      state;
  state_t      stateNext;
  logic [HW-1:0] holdCnt;
  logic [HW-1:0] holdNext;
  logic [2:0]  codeNext;
  logic        hitNext;
  logic        multiNext;
  logic [2:0]  hitCode;
  logic [3:0]  pressNum;

  always_ff @(posedge clock) begin
    if (reset) begin
      syncMeta <= '0;
      syncKey  <= '0;
    end else begin
      syncMeta <= rawKeys;
      syncKey  <= syncMeta;
    end
  end

  // Level change accepted only after DEBOUNCE_CYCLES differing samples.
  always_ff @(posedge clock) begin
    if (reset) begin
      stable     <= '0;
      stablePrev <= '0;
      for (int i = 0; i < NUM_KEYS; i++)
        debCnt[i] <= '0;
    end else begin
      stablePrev <= stable;
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (syncKey[i] == stable[i]) begin
          debCnt[i] <= '0;
        end else if (debCnt[i] ==
                     CW'(DEBOUNCE_CYCLES - 1)) begin
          stable[i] <= syncKey[i];
          debCnt[i] <= '0;
        end else begin
          debCnt[i] <= debCnt[i] + 1'b1;
        end
      end
    end
  end

  assign press = stable & ~stablePrev;

  always_comb begin
    hitCode  = 3'd0;
    pressNum = 4'd0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (press[i])
        hitCode = 3'(i + 1);
    end
    for (int i = 0; i < NUM_KEYS; i++)
      pressNum = pressNum + {3'd0, press[i]};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      holdCnt       <= '0;
      userGameInput <= 3'd0;
      hitPulse      <= 1'b0;
      multiPress    <= 1'b0;
    end else begin
      state         <= stateNext;
      holdCnt       <= holdNext;
      userGameInput <= codeNext;
      hitPulse      <= hitNext;
      multiPress    <= multiNext;
    end
  end

  always_comb begin
    stateNext = state;
    holdNext  = holdCnt;
    codeNext  = userGameInput;
    hitNext   = 1'b0;
    multiNext = 1'b0;
    if (!enable) begin
      stateNext = IDLE;
      holdNext  = '0;
      codeNext  = 3'd0;
    end else begin
      case (state)
        IDLE: begin
          codeNext = 3'd0;
          if (|press) begin
            codeNext  = hitCode;
            hitNext   = 1'b1;
            multiNext = (pressNum >= 4'd2);
            holdNext  = HW'(HOLD_CYCLES - 1);
            stateNext = HOLD;
          end
        end
        HOLD: begin
          if (holdCnt == '0) begin
            codeNext  = 3'd0;
            stateNext = RELEASE_WAIT;
          end else begin
            holdNext = holdCnt - 1'b1;
          end
        end
        RELEASE_WAIT: begin
          // Wait for full release so a held key cannot re-fire.
          if (stable == '0)
            stateNext = IDLE;
        end
        default: begin
          stateNext = IDLE;
          codeNext  = 3'd0;
          holdNext  = '0;
        end
      endcase
    end
  end

`ifdef PRESS_COUNT_EN
  logic enablePrev;

  always_ff @(posedge clock) begin
    if (reset) begin
      enablePrev <= 1'b0;
      pressCount <= 8'd0;
    end else begin
      enablePrev <= enable;
      if (enable && !enablePrev)
        pressCount <= 8'd0;
      else if (hitPulse && pressCount != 8'hFF)
        pressCount <= pressCount + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_whack_input_encoder.sv
// Scoreboard bench for whack_input_encoder (DEBOUNCE=4, HOLD=3).
// Expected hits are queued by stimulus; a monitor checks each hitPulse.
module tb_whack_input_encoder;

  logic       clock;
  logic       reset;
  logic       enable;
  logic [4:0] rawKeys;
  logic [2:0] userGameInput;
  logic       hitPulse;
  logic       multiPress;
`ifdef PRESS_COUNT_EN
  logic [7:0] pressCount;
`endif

  whack_input_encoder #(
    .NUM_KEYS(5),
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES(3)
  ) dut (
    .clock(clock),
    .reset(reset),
    .enable(enable),
    .rawKeys(rawKeys),
    .userGameInput(userGameInput),
    .hitPulse(hitPulse),
`ifdef PRESS_COUNT_EN
    .multiPress(multiPress),
    .pressCount(pressCount)
`else
    .multiPress(multiPress)
`endif
  );

  typedef struct {
    int code;
    int multi;
    int len;
  } exp_t;

  exp_t sb[$];
  int   nChecks = 0;
  int   nFails  = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name,
                       input int act,
                       input int exp);
    nChecks++;
    if (act != exp) begin
      nFails++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic expect_hit(input int code,
                            input int multi,
                            input int len);
    exp_t e;
    e.code  = code;
    e.multi = multi;
    e.len   = len;
    sb.push_back(e);
  endtask

  // Monitor: pops on every hitPulse, then measures the hold length.
  initial begin
    exp_t cur;
    int   len;
    bit   tracking;
    tracking = 0;
    len = 0;
    cur.code = 0;
    cur.multi = 0;
    cur.len = 0;
    forever begin
      @(negedge clock);
      if (reset) begin
        tracking = 0;
      end else if (hitPulse) begin
        if (sb.size() == 0) begin
          check("unexpectedHit", int'(hitPulse), 0);
        end else begin
          cur = sb.pop_front();
          check("hitCode", int'(userGameInput), cur.code);
          check("hitMulti", int'(multiPress), cur.multi);
          tracking = 1;
          len = 1;
        end
      end else if (tracking) begin
        check("pulseWidth", int'(hitPulse), 0);
        if (userGameInput != 3'd0) begin
          check("heldCode", int'(userGameInput), cur.code);
          len++;
        end else begin
          check("holdLen", len, cur.len);
          tracking = 0;
        end
      end
    end
  end

  initial begin
    bit seen5;
    reset   = 1'b1;
    enable  = 1'b1;
    rawKeys = 5'b0;
    tick(3);
    check("rstCode", int'(userGameInput), 0);
    check("rstHit", int'(hitPulse), 0);
    check("rstMulti", int'(multiPress), 0);
    reset = 1'b0;
    tick(3);

    // Latency and hold length on key 2.
    expect_hit(3, 0, 3);
    rawKeys = 5'b00100;
    tick(6);
    check("latencyEarly", int'(hitPulse), 0);
    tick(1);
    check("latencyEdge7", int'(hitPulse), 1);
    check("latencyCode", int'(userGameInput), 3);
    tick(2);
    check("holdLast", int'(userGameInput), 3);
    tick(1);
    check("holdRelease", int'(userGameInput), 0);
    tick(20);
    check("noRetrigger", int'(userGameInput), 0);
    rawKeys = 5'b0;
    tick(12);
    expect_hit(3, 0, 3);
    rawKeys = 5'b00100;
    tick(12);
    rawKeys = 5'b0;
    tick(12);

    // Glitch shorter than the debounce window.
    rawKeys = 5'b00001;
    tick(3);
    rawKeys = 5'b0;
    tick(15);
    check("glitchCode", int'(userGameInput), 0);

    // Simultaneous keys 1 and 3.
    expect_hit(2, 1, 3);
    rawKeys = 5'b01010;
    tick(12);
    rawKeys = 5'b0;
    tick(12);

    // Lockout: key 4 during HOLD/RELEASE_WAIT.
    expect_hit(2, 0, 3);
    rawKeys = 5'b00010;
    tick(8);
    rawKeys = 5'b10010;
    seen5 = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (userGameInput == 3'd5) seen5 = 1;
    end
    rawKeys = 5'b0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (userGameInput == 3'd5) seen5 = 1;
    end
    check("lockoutNo5", int'(seen5), 0);

    // Key held across an enable rise.
    enable  = 1'b0;
    rawKeys = 5'b01000;
    tick(12);
    enable = 1'b1;
    tick(12);
    check("heldAtEnable", int'(userGameInput), 0);
    rawKeys = 5'b0;
    tick(12);
    expect_hit(4, 0, 3);
    rawKeys = 5'b01000;
    tick(12);
    rawKeys = 5'b0;
    tick(12);

    // Enable dropped mid-HOLD.
    expect_hit(4, 0, 2);
    rawKeys = 5'b01000;
    tick(8);
    check("midHoldBefore", int'(userGameInput), 4);
    enable = 1'b0;
    tick(1);
    check("midHoldDrop", int'(userGameInput), 0);
    enable = 1'b1;
    rawKeys = 5'b0;
    tick(12);

`ifdef PRESS_COUNT_EN
    enable = 1'b0;
    tick(1);
    enable = 1'b1;
    tick(1);
    check("cntClear0", int'(pressCount), 0);
    for (int i = 0; i < 300; i++) begin
      expect_hit(1, 0, 3);
      rawKeys = 5'b00001;
      tick(10);
      rawKeys = 5'b0;
      tick(10);
    end
    check("cntSat", int'(pressCount), 255);
    enable = 1'b0;
    tick(1);
    enable = 1'b1;
    tick(1);
    check("cntClear1", int'(pressCount), 0);
`endif

    tick(5);
    check("sbDrained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFails);
    $finish;
  end

endmodule
